// File: rtl/core_pkg.sv
// Shared types and sizing for the physical-register free-list controller.
package core_pkg;

  localparam int unsigned FETCH_W   = 2;
  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned PHYS_REGS = 48;
  localparam int unsigned PREG_W    = 6;
  localparam int unsigned FL_DEPTH  = PHYS_REGS - ARCH_REGS;
  localparam int unsigned IDX_W     = $clog2(FL_DEPTH);
  localparam int unsigned PTR_W     = IDX_W + 1;
  localparam int unsigned CNT_W     = $clog2(FL_DEPTH + 1);
  localparam int unsigned NEED_W    = $clog2(FETCH_W + 1);

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PTR_W-1:0]  fl_ptr_t;

  typedef enum logic [1:0] {
    FL_INIT,
    FL_READY,
    FL_RECOVER
  } fl_state_e;

endpackage

// File: rtl/lane_offset_calc.sv
// Per-lane prefix popcount of requests, giving each lane its free-list slot
// relative to head, plus the total number of slots requested.
module lane_offset_calc
  import core_pkg::*;
(
  input  logic [FETCH_W-1:0]            req_i,
  input  logic [IDX_W-1:0]              head_idx_i,
  output logic [NEED_W-1:0]             need_o,
  output logic [FETCH_W-1:0][IDX_W-1:0] idx_o
);

  always_comb begin
    logic [NEED_W-1:0] run;
    run   = '0;
    idx_o = '0;
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      idx_o[i] = head_idx_i + IDX_W'(run);
      run      = run + NEED_W'(req_i[i]);
    end
    need_o = run;
  end

endmodule

// File: rtl/preg_alloc_ctrl.sv
// Free-list controller: all-or-nothing multi-lane preg allocation, commit-time
// reclaim and flush recovery via a committed head. FREELIST_PERF_EN adds counters.
module preg_alloc_ctrl
  import core_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [FETCH_W-1:0]   alloc_req,
  output logic                 alloc_ready,
  output logic [FETCH_W-1:0]   alloc_grant,
  output preg_t [FETCH_W-1:0]  alloc_preg,
  input  logic                 commit_en,
  input  logic                 commit_has_rd,
  input  preg_t                commit_old_preg,
  input  logic                 flush,
  output logic [CNT_W-1:0]     free_count,
  output logic                 init_done,
  output logic                 err_overflow,
  output logic [31:0]          perf_stall_cycles,
  output logic [15:0]          perf_flushes
);

  fl_state_e          state_q, state_d;
  fl_ptr_t            head_q, head_d;
  fl_ptr_t            tail_q, tail_d;
  fl_ptr_t            chead_q, chead_d;
  logic [IDX_W-1:0]   init_idx_q, init_idx_d;
  logic               init_done_q, init_done_d;
  logic               err_q, err_d;
  preg_t              mem_q [FL_DEPTH];

  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  preg_t              wr_data;
  logic               commit_push;
  logic [NEED_W-1:0]  need;
  logic [FETCH_W-1:0][IDX_W-1:0] lane_idx;

  lane_offset_calc u_lane_offset_calc (
    .req_i      (alloc_req),
    .head_idx_i (head_q[IDX_W-1:0]),
    .need_o     (need),
    .idx_o      (lane_idx)
  );

  assign free_count   = CNT_W'(tail_q - head_q);
  assign init_done    = init_done_q;
  assign err_overflow = err_q;
  assign commit_push  = commit_en & commit_has_rd;
  assign alloc_ready  = (state_q == FL_READY) && !flush && (free_count >= CNT_W'(need));
  assign alloc_grant  = alloc_req & {FETCH_W{alloc_ready}};

  always_comb begin
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      alloc_preg[i] = alloc_grant[i] ? mem_q[lane_idx[i]] : '0;
    end
  end

  // Next-state: INIT populates the list; READY/RECOVER handle commits and flush.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    chead_d     = chead_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    wr_en       = 1'b0;
    wr_idx      = tail_q[IDX_W-1:0];
    wr_data     = commit_old_preg;

    case (state_q)
      FL_INIT: begin
        wr_en      = 1'b1;
        wr_idx     = init_idx_q;
        wr_data    = PREG_W'(ARCH_REGS) + PREG_W'(init_idx_q);
        init_idx_d = init_idx_q + IDX_W'(1);
        if (init_idx_q == IDX_W'(FL_DEPTH - 1)) begin
          tail_d      = PTR_W'(FL_DEPTH);
          init_done_d = 1'b1;
          state_d     = FL_READY;
        end
      end
      FL_READY, FL_RECOVER: begin
        if (commit_push) begin
          chead_d = chead_q + PTR_W'(1);
          if (free_count == CNT_W'(FL_DEPTH)) begin
            err_d = 1'b1;
          end else begin
            wr_en  = 1'b1;
            tail_d = tail_q + PTR_W'(1);
          end
        end
        // Recovery rewinds to the committed head including this cycle's commit.
        if (state_q == FL_RECOVER) begin
          head_d = chead_d;
        end else if (alloc_ready) begin
          head_d = head_q + PTR_W'(need);
        end
        state_d = flush ? FL_RECOVER : FL_READY;
      end
      default: state_d = FL_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FL_INIT;
      head_q      <= '0;
      tail_q      <= '0;
      chead_q     <= '0;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      chead_q     <= chead_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

`ifdef FREELIST_PERF_EN
  logic [31:0] perf_stall_q;
  logic [15:0] perf_flush_q;

  // Saturating stall and recovery-entry counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if ((state_q == FL_READY) && (|alloc_req) && !alloc_ready && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (flush && (state_q != FL_INIT) && (perf_flush_q != '1)) begin
        perf_flush_q <= perf_flush_q + 16'd1;
      end
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flushes      = perf_flush_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_flushes      = '0;
`endif

endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Directed, table-driven bench for preg_alloc_ctrl.
module tb_preg_alloc_ctrl;
  import core_pkg::*;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [FETCH_W-1:0]  alloc_req = '0;
  logic                alloc_ready;
  logic [FETCH_W-1:0]  alloc_grant;
  preg_t [FETCH_W-1:0] alloc_preg;
  logic                commit_en = 1'b0;
  logic                commit_has_rd = 1'b0;
  preg_t               commit_old_preg = '0;
  logic                flush = 1'b0;
  logic [CNT_W-1:0]    free_count;
  logic                init_done;
  logic                err_overflow;
  logic [31:0]         perf_stall_cycles;
  logic [15:0]         perf_flushes;

  int checks = 0;
  int errors = 0;

  preg_alloc_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .alloc_req         (alloc_req),
    .alloc_ready       (alloc_ready),
    .alloc_grant       (alloc_grant),
    .alloc_preg        (alloc_preg),
    .commit_en         (commit_en),
    .commit_has_rd     (commit_has_rd),
    .commit_old_preg   (commit_old_preg),
    .flush             (flush),
    .free_count        (free_count),
    .init_done         (init_done),
    .err_overflow      (err_overflow),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic       ce;
    logic       hr;
    logic [5:0] old;
    logic       rdy;
    logic [1:0] gnt;
    logic [5:0] p0;
    logic [5:0] p1;
    logic [4:0] cnt;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] req, input logic ce, input logic hr,
                       input logic [5:0] old, input logic fl);
    alloc_req       = req;
    commit_en       = ce;
    commit_has_rd   = hr;
    commit_old_preg = old;
    flush           = fl;
    #1;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (init_done !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
  endtask

  task automatic do_reset();
    int n;
    reset = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 6'd0, 1'b0);
    cycle();
    cycle();
    reset = 1'b1;
    wait_init(n);
    check("init_cycles", n, 16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k0, k1;

    vecs[0]  = '{2'b11, 1'b0, 1'b0, 6'd0, 1'b1, 2'b11, 6'd32, 6'd33, 5'd16};
    vecs[1]  = '{2'b11, 1'b0, 1'b0, 6'd0, 1'b1, 2'b11, 6'd34, 6'd35, 5'd14};
    vecs[2]  = '{2'b10, 1'b0, 1'b0, 6'd0, 1'b1, 2'b10, 6'd0,  6'd36, 5'd12};
    vecs[3]  = '{2'b00, 1'b0, 1'b0, 6'd0, 1'b1, 2'b00, 6'd0,  6'd0,  5'd11};
    vecs[4]  = '{2'b11, 1'b0, 1'b0, 6'd0, 1'b1, 2'b11, 6'd37, 6'd38, 5'd11};
    vecs[5]  = '{2'b11, 1'b0, 1'b0, 6'd0, 1'b1, 2'b11, 6'd39, 6'd40, 5'd9};
    vecs[6]  = '{2'b11, 1'b0, 1'b0, 6'd0, 1'b1, 2'b11, 6'd41, 6'd42, 5'd7};
    vecs[7]  = '{2'b11, 1'b0, 1'b0, 6'd0, 1'b1, 2'b11, 6'd43, 6'd44, 5'd5};
    vecs[8]  = '{2'b11, 1'b0, 1'b0, 6'd0, 1'b1, 2'b11, 6'd45, 6'd46, 5'd3};
    vecs[9]  = '{2'b11, 1'b0, 1'b0, 6'd0, 1'b0, 2'b00, 6'd0,  6'd0,  5'd1};
    vecs[10] = '{2'b01, 1'b0, 1'b0, 6'd0, 1'b1, 2'b01, 6'd47, 6'd0,  5'd1};
    vecs[11] = '{2'b01, 1'b1, 1'b1, 6'd5, 1'b0, 2'b00, 6'd0,  6'd0,  5'd0};
    vecs[12] = '{2'b01, 1'b0, 1'b0, 6'd0, 1'b1, 2'b01, 6'd5,  6'd0,  5'd1};
    vecs[13] = '{2'b00, 1'b1, 1'b0, 6'd9, 1'b1, 2'b00, 6'd0,  6'd0,  5'd0};
    vecs[14] = '{2'b00, 1'b0, 1'b0, 6'd0, 1'b1, 2'b00, 6'd0,  6'd0,  5'd0};

    // Reset for two cycles, then watch the 16-cycle population.
    reset = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 6'd0, 1'b0);
    check("reset_ready", int'(alloc_ready), 0);
    check("reset_grant", int'(alloc_grant), 0);
    check("reset_err", int'(err_overflow), 0);
    cycle();
    cycle();
    reset = 1'b1;
    for (int c = 0; c < 16; c++) begin
      drive(2'b11, 1'b0, 1'b0, 6'd0, 1'b0);
      check("init_busy_done", int'(init_done), 0);
      check("init_busy_ready", int'(alloc_ready), 0);
      cycle();
    end
    drive(2'b11, 1'b0, 1'b0, 6'd0, 1'b0);
    check("init_done", int'(init_done), 1);
    check("init_count", int'(free_count), 16);
    check("init_preg0", int'(alloc_preg[0]), 32);
    check("init_preg1", int'(alloc_preg[1]), 33);

    // Allocation, drain, starvation and commit-at-empty vectors.
    for (int v = 0; v < 15; v++) begin
      drive(vecs[v].req, vecs[v].ce, vecs[v].hr, vecs[v].old, 1'b0);
      check($sformatf("v%0d_ready", v), int'(alloc_ready), int'(vecs[v].rdy));
      check($sformatf("v%0d_grant", v), int'(alloc_grant), int'(vecs[v].gnt));
      check($sformatf("v%0d_preg0", v), int'(alloc_preg[0]), int'(vecs[v].p0));
      check($sformatf("v%0d_preg1", v), int'(alloc_preg[1]), int'(vecs[v].p1));
      check($sformatf("v%0d_count", v), int'(free_count), int'(vecs[v].cnt));
      check($sformatf("v%0d_err", v), int'(err_overflow), 0);
      cycle();
    end

    // Flush recovery: 4 allocs, one commit of preg 7, flush, one RECOVER cycle.
    do_reset();
    drive(2'b11, 1'b0, 1'b0, 6'd0, 1'b0);
    check("fl_a0", int'(alloc_preg[0]), 32);
    cycle();
    drive(2'b11, 1'b0, 1'b0, 6'd0, 1'b0);
    check("fl_a1", int'(alloc_preg[1]), 35);
    cycle();
    drive(2'b00, 1'b1, 1'b1, 6'd7, 1'b0);
    check("fl_cnt_pre", int'(free_count), 12);
    cycle();
    drive(2'b11, 1'b0, 1'b0, 6'd0, 1'b1);
    check("fl_flush_ready", int'(alloc_ready), 0);
    check("fl_flush_grant", int'(alloc_grant), 0);
    check("fl_flush_cnt", int'(free_count), 13);
    cycle();
    drive(2'b11, 1'b0, 1'b0, 6'd0, 1'b0);
    check("fl_recover_ready", int'(alloc_ready), 0);
    check("fl_recover_grant", int'(alloc_grant), 0);
    cycle();
    drive(2'b00, 1'b0, 1'b0, 6'd0, 1'b0);
    check("fl_post_cnt", int'(free_count), 16);
    check("fl_post_ready", int'(alloc_ready), 1);
    for (int j = 0; j < 8; j++) begin
      k0 = 2 * j;
      k1 = 2 * j + 1;
      drive(2'b11, 1'b0, 1'b0, 6'd0, 1'b0);
      check($sformatf("fl_list%0d", k0), int'(alloc_preg[0]), (k0 < 15) ? 33 + k0 : 7);
      check($sformatf("fl_list%0d", k1), int'(alloc_preg[1]), (k1 < 15) ? 33 + k1 : 7);
      cycle();
    end
    drive(2'b00, 1'b0, 1'b0, 6'd0, 1'b0);
    check("fl_empty_cnt", int'(free_count), 0);

    // Overflow on a full list; RECOVER uses commit_head after its own commit.
    do_reset();
    drive(2'b00, 1'b1, 1'b1, 6'd3, 1'b0);
    check("ov_pre_err", int'(err_overflow), 0);
    check("ov_pre_cnt", int'(free_count), 16);
    cycle();
    drive(2'b00, 1'b0, 1'b0, 6'd0, 1'b0);
    check("ov_err", int'(err_overflow), 1);
    check("ov_cnt", int'(free_count), 16);
    cycle();
    drive(2'b11, 1'b0, 1'b0, 6'd0, 1'b1);
    check("ov_flush_ready", int'(alloc_ready), 0);
    check("ov_err_sticky", int'(err_overflow), 1);
    cycle();
    drive(2'b00, 1'b1, 1'b1, 6'd4, 1'b0);
    check("ov_recover_ready", int'(alloc_ready), 0);
    cycle();
    drive(2'b00, 1'b0, 1'b0, 6'd0, 1'b0);
    check("ov_recover_cnt", int'(free_count), 14);
    check("ov_err_sticky2", int'(err_overflow), 1);
    reset = 1'b0;
    #1;
    check("ov_reset_err", int'(err_overflow), 0);
    check("ov_reset_done", int'(init_done), 0);

    // Reset reasserted part-way through INIT restarts population from index 0.
    cycle();
    cycle();
    reset = 1'b1;
    repeat (5) cycle();
    check("mid_init_done", int'(init_done), 0);
    reset = 1'b0;
    #1;
    check("mid_reset_cnt", int'(free_count), 0);
    cycle();
    reset = 1'b1;
    wait_init(n);
    check("mid_init_cycles", n, 16);
    drive(2'b11, 1'b0, 1'b0, 6'd0, 1'b0);
    check("mid_preg0", int'(alloc_preg[0]), 32);
    check("mid_preg1", int'(alloc_preg[1]), 33);
    check("mid_cnt", int'(free_count), 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/preg_alloc_ctrl.md
Name: preg_alloc_ctrl

Overview:
- FIFO free-list controller that hands out physical destination registers to the FETCH_W rename lanes.
- Reclaims the old mappings of committed instructions.
- Restores speculative allocations on a pipeline flush using a committed head pointer.
- Sits between rename and commit. It replaces the per-lane bitmask allocators with one multi-grant, all-or-nothing scheduler.

Parameters:
- FETCH_W, 2, rename lanes served per cycle
- ARCH_REGS, 32, architectural registers (pregs 0..ARCH_REGS-1 are the reset mappings)
- PHYS_REGS, 48, total physical registers
- PREG_W, 6, physical register index width
- FL_DEPTH, PHYS_REGS-ARCH_REGS (16), free-list entries

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- alloc_req  in  FETCH_W  per-lane request for a new preg
- alloc_ready  out  1  all current requests can be granted this cycle
- alloc_grant  out  FETCH_W  per-lane grant, equals alloc_req & alloc_ready
- alloc_preg  out  FETCH_W x PREG_W  preg assigned to each lane
- commit_en  in  1  one instruction commits
- commit_has_rd  in  1  committing instruction allocated a preg
- commit_old_preg  in  PREG_W  previous mapping of its rd, to be freed
- flush  in  1  squash all speculative allocations
- free_count  out  $clog2(FL_DEPTH+1)  entries currently free (speculative view)
- init_done  out  1  free list populated
- err_overflow  out  1  sticky: push attempted while list full

Behaviour:
- Storage: FL_DEPTH x PREG_W array.
- Pointers: head, commit_head and tail, each $clog2(FL_DEPTH)+1 bits with a wrap bit. free_count = tail - head.
- Reset (async, reset==0): state INIT, all pointers 0, init index 0, err_overflow 0, init_done 0, alloc_ready 0, alloc_grant 0, alloc_preg 0.
- INIT state:
  - Writes entry k = ARCH_REGS+k, one per cycle, for FL_DEPTH cycles.
  - On the last write: tail=FL_DEPTH (wrap bit set, index 0), state READY, init_done 1.
  - Commit and flush inputs are ignored.
- READY state, allocation:
  - need = popcount(alloc_req). alloc_ready = (free_count >= need) and not flush.
  - alloc_ready is combinational from registered state; there is no same-cycle bypass of frees.
- READY state, lane assignment:
  - Lane i takes entry head + popcount(alloc_req[i-1:0]); lane 0 takes head.
  - alloc_preg is combinational and valid only where granted.
  - On grant, head advances by need at the clock edge. All-or-nothing: no partial grants.
- Commit, when commit_en & commit_has_rd:
  - Write commit_old_preg at tail; tail+1; commit_head+1.
  - If free_count==FL_DEPTH: drop the push, set err_overflow, commit_head still advances.
- flush (any cycle in READY):
  - No grants that cycle; state RECOVER.
- RECOVER (1 cycle):
  - head <= commit_head, using commit_head after that cycle's commit.
  - alloc_ready 0; commits still processed. Then READY.
- Simultaneous events:
  - Alloc plus commit in the same cycle: head and tail/commit_head update independently.
  - flush held high for multiple cycles re-enters RECOVER each cycle.
- Reset mid-operation: immediate return to INIT, full repopulation; the contents of err_overflow are lost.

Optional Feature:
- FREELIST_PERF_EN. When defined, adds outputs perf_stall_cycles[31:0] and perf_flushes[15:0], both reset to 0.
  - perf_stall_cycles increments each READY cycle with |alloc_req & !alloc_ready.
  - perf_flushes increments on each RECOVER entry.
  - Both saturate.
- When undefined, both ports exist and are tied to 0; no counter flops.

Decomposition:
- core_pkg gets:
  - preg_t (logic [PREG_W-1:0])
  - FL_DEPTH constant derived from PREGS and arch register count
  - fl_state_e {FL_INIT, FL_READY, FL_RECOVER}
- One sub-module, lane_offset_calc: computes per-lane prefix popcounts and entry indices. It is combinational and reused by future multi-issue allocators.

Test Plan:
- Reset low for 2 cycles, then release. Required: init_done=0 and alloc_ready=0 for 16 cycles; then init_done=1, free_count=16, and with req=2'b11 alloc_preg={33,32}.
- req=2'b11 granted twice. Required: pregs 32,33 then 34,35; free_count=12. Then req=2'b10: lane1 gets 36, count=11.
- Drain to free_count=1, then req=2'b11. Required: alloc_ready=0, grant=00, head unchanged. req=2'b01: grant, preg 47, count=0.
- At count=0, commit_old_preg=5 with req=2'b01 in the same cycle. Required: no grant. Next cycle: count=1, and req=2'b01 gets preg 5.
- 4 allocations, 1 commit (old preg 7), then flush. Required: one RECOVER cycle with alloc_ready=0; after it free_count=16 and the list holds 33..47,7 from head.
- Full list, force commit push. Required: err_overflow=1 sticky, free_count stays 16. Also assert reset during INIT at cycle 5: init restarts from index 0.
